// File: rtl/universal_shift_receiver.sv
// -----------------------------------------------------------------------------
// universal_shift_receiver
//
// Serial-to-parallel receiver for the far end of a universal-shift-register
// link. Reassembles WIDTH-bit words arriving one bit per accepted cycle, in
// either LSB-first or MSB-first order, into a one-entry output buffer that
// drains through a valid/ready handshake. Words that complete while the
// buffer is full are dropped and flagged with a sticky overrun.
//
// Optional feature macro: SHIFT_RX_PARITY_EN
//   defined   : frame is WIDTH data bits + 1 trailing even-parity bit;
//               parity_err is registered with out_data.
//   undefined : frame is WIDTH data bits; parity_err is tied to 0.
//
// Ports
//   CLK        in   1          clock, rising edge
//   Clear      in   1          synchronous active-high reset (highest priority)
//   sel_dir    in   1          0 = LSB-first stream, 1 = MSB-first stream
//                              (latched on the first bit of each frame)
//   ser_in     in   1          serial data bit
//   ser_valid  in   1          ser_in carries a bit this cycle
//   out_data   out  WIDTH      assembled word
//   out_valid  out  1          out_data holds an unconsumed word
//   out_ready  in   1          consumer takes out_data this cycle
//   overrun    out  1          sticky: a completed word was dropped
//   parity_err out  1          parity mismatch on the word in out_data
//   bit_count  out  clog2(WIDTH+2)  bits collected in the current frame
// -----------------------------------------------------------------------------
module universal_shift_receiver #(
  parameter int WIDTH = 4
) (
  input  logic                         CLK,
  input  logic                         Clear,
  input  logic                         sel_dir,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic                         parity_err,
  output logic [$clog2(WIDTH+2)-1:0]   bit_count
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SHIFT_RX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  // Frame phase: COLLECT while bits accumulate, FRAME_DONE on the single
  // cycle in which the final bit of a frame is accepted.
  typedef enum logic {
    COLLECT    = 1'b0,
    FRAME_DONE = 1'b1
  } phase_e;

  phase_e phase;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef SHIFT_RX_PARITY_EN
  logic             par_q, par_d;     // running XOR of the bits of this frame
  logic             perr_q, perr_d;
`endif

  logic [WIDTH-1:0] shr;              // register shifted right, new bit at MSB
  logic [WIDTH-1:0] shl;              // register shifted left, new bit at LSB
  logic             cur_dir;
  logic [WIDTH-1:0] word_new;
  logic             buf_free;
  logic             drain;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_shr_top
        assign shr[gi] = ser_in;
      end else begin : g_shr_mid
        assign shr[gi] = shift_q[gi+1];
      end
      if (gi == 0) begin : g_shl_bot
        assign shl[gi] = ser_in;
      end else begin : g_shl_mid
        assign shl[gi] = shift_q[gi-1];
      end
    end
  endgenerate

  // The first bit of a frame must already use the new direction, so it is
  // taken straight from sel_dir rather than from the latched copy.
  assign cur_dir  = (cnt_q == '0) ? sel_dir : dir_q;
  assign drain    = valid_q && out_ready;
  assign buf_free = !valid_q || out_ready;

`ifdef SHIFT_RX_PARITY_EN
  // The last accepted bit is the parity bit, so the data register is already
  // complete when the frame finishes.
  assign word_new = shift_q;
`else
  // The last accepted bit is the last data bit; deliver the post-shift value.
  assign word_new = cur_dir ? shl : shr;
`endif

  always_comb begin
    phase = COLLECT;
    if (ser_valid && (cnt_q == LAST_IDX)) begin
      phase = FRAME_DONE;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef SHIFT_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif

    if (ser_valid) begin
      if (cnt_q == '0) begin
        dir_d = sel_dir;
      end
`ifdef SHIFT_RX_PARITY_EN
      // The parity bit never enters the data register.
      if (cnt_q != LAST_IDX) begin
        shift_d = cur_dir ? shl : shr;
      end
      par_d = (phase == FRAME_DONE) ? 1'b0 : (par_q ^ ser_in);
`else
      shift_d = cur_dir ? shl : shr;
`endif
      cnt_d = (phase == FRAME_DONE) ? '0 : (cnt_q + 1'b1);
    end

    if (drain) begin
      valid_d = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    if (phase == FRAME_DONE) begin
      if (buf_free) begin
        // A load in the same cycle as a drain keeps out_valid high.
        valid_d = 1'b1;
        data_d  = word_new;
`ifdef SHIFT_RX_PARITY_EN
        perr_d  = par_q ^ ser_in;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      shift_q   <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SHIFT_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign bit_count = cnt_q;
`ifdef SHIFT_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_receiver.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_receiver
//
// Scoreboard bench for universal_shift_receiver. A reference model collects
// accepted bits into a queue per frame and builds each completed word with
// plain arithmetic (bit i of the frame goes to weight 2^i or 2^(WIDTH-1-i)).
// Completed words that fit in the one-entry buffer are pushed to a scoreboard
// queue; a monitor on the falling edge pops and compares whenever the DUT
// transfers a word, and checks the per-cycle status outputs.
// -----------------------------------------------------------------------------
module tb_universal_shift_receiver;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 2);
`ifdef SHIFT_RX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic              CLK = 1'b0;
  logic              Clear = 1'b1;
  logic              sel_dir = 1'b0;
  logic              ser_in = 1'b0;
  logic              ser_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              overrun;
  logic              parity_err;
  logic [CW-1:0]     bit_count;

  universal_shift_receiver #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .sel_dir    (sel_dir),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .parity_err (parity_err),
    .bit_count  (bit_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             perr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  bit               frame_bits[$];
  bit               m_dir;
  bit               m_full;
  bit               m_overrun;
  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_word;
  logic             m_par;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated on every rising edge from the inputs the
  // driver set up during the previous cycle.
  initial begin
    m_dir = 1'b0;
    m_full = 1'b0;
    m_overrun = 1'b0;
    forever begin
      @(posedge CLK);
      if (Clear) begin
        frame_bits.delete();
        sb_q.delete();
        m_dir = 1'b0;
        m_full = 1'b0;
        m_overrun = 1'b0;
      end else begin
        if (m_full && out_ready) m_full = 1'b0;
        if (ser_valid) begin
          if (frame_bits.size() == 0) m_dir = sel_dir;
          frame_bits.push_back(ser_in);
          if (frame_bits.size() == FL) begin
            m_word = '0;
            m_par = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
              if (frame_bits[i])
                m_word = m_word + (WIDTH'(1) << (m_dir ? (WIDTH - 1 - i) : i));
            end
`ifdef SHIFT_RX_PARITY_EN
            for (int i = 0; i < FL; i++) m_par = m_par ^ frame_bits[i];
`endif
            if (m_full) begin
              m_overrun = 1'b1;
            end else begin
              m_full = 1'b1;
              sb_q.push_back('{data: m_word, perr: m_par});
            end
            frame_bits.delete();
          end
        end
      end
    end
  end

  // Monitor: one line per transferred word, checks against scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("overrun", 32'(overrun), 32'(m_overrun));
        check("bit_count", 32'(bit_count), 32'(frame_bits.size()));
        if (!out_valid) check("parity_err_idle", 32'(parity_err), 32'd0);
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got word %0h expected no word (t=%0t)", out_data, $time);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            $display("xfer data=%0h perr=%0b (t=%0t)", out_data, parity_err, $time);
          end else begin
            check("out_data_hold", 32'(out_data), 32'(sb_q[0].data));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    ser_in = b;
    sel_dir = d;
    ser_valid = 1'b1;
    step();
    ser_valid = 1'b0;
  endtask

  function automatic logic [FL-1:0] make_frame(input logic [WIDTH-1:0] w);
`ifdef SHIFT_RX_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // Bit 0 of fr goes first; the first bit uses d0, the rest use d1.
  task automatic send_frame(input logic [FL-1:0] fr, input logic d0, input logic d1);
    for (int i = 0; i < FL; i++) send_bit(fr[i], (i == 0) ? d0 : d1);
  endtask

  initial begin
    logic [FL-1:0] fr;
    // Reset, all outputs held at zero
    Clear = 1'b1;
    step();
    mon_en = 1'b1;
    check("rst_out_data", 32'(out_data), 32'd0);
    step();
    Clear = 1'b0;
    out_ready = 1'b1;

    // LSB-first: bits 1,1,0,1 -> 4'b1011
    send_frame(make_frame(4'b1011), 1'b0, 1'b0);
    check("lsb_valid", 32'(out_valid), 32'd1);
    check("lsb_data", 32'(out_data), 32'hB);

    // MSB-first: bits 1,0,1,1 -> 4'b1011, direction toggled after first bit
    send_frame(make_frame(4'b1101), 1'b1, 1'b0);
    check("msb_data", 32'(out_data), 32'hB);

    // Back-to-back frames with continuous ser_valid
    for (int f = 0; f < 3; f++) begin
      fr = make_frame(WIDTH'($urandom));
      for (int i = 0; i < FL; i++) begin
        ser_in = fr[i];
        sel_dir = 1'b0;
        ser_valid = 1'b1;
        step();
      end
    end
    ser_valid = 1'b0;

    // Final bit coinciding with a drain keeps out_valid high
    out_ready = 1'b0;
    send_frame(make_frame(4'b0110), 1'b0, 1'b0);
    fr = make_frame(4'b1001);
    for (int i = 0; i < FL - 1; i++) send_bit(fr[i], 1'b1);
    out_ready = 1'b1;
    send_bit(fr[FL-1], 1'b1);
    check("coincide_valid", 32'(out_valid), 32'd1);
    check("coincide_data", 32'(out_data), 32'h9);
    step();

    // Gaps and back-pressure: bits 1,0 then 3 idle, then 1,1 -> 4'b1101
    fr = make_frame(4'b1101);
    send_bit(fr[0], 1'b0);
    send_bit(fr[1], 1'b0);
    repeat (3) step();
    check("gap_count", 32'(bit_count), 32'd2);
    out_ready = 1'b0;
    for (int i = 2; i < FL; i++) send_bit(fr[i], 1'b0);
    send_frame(make_frame(4'b1000), 1'b0, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_data", 32'(out_data), 32'hD);
    out_ready = 1'b1;
    step();

    // Reset mid-frame: 2 bits of 0101, Clear, then fresh 0011 -> 4'b1100
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    send_frame(make_frame(4'b1100), 1'b0, 1'b0);
    check("clr_data", 32'(out_data), 32'hC);

`ifdef SHIFT_RX_PARITY_EN
    // Good parity then bad parity, both deliver 4'b1011
    send_frame({1'b1, 4'b1011}, 1'b0, 1'b0);
    check("par_good", 32'(parity_err), 32'd0);
    check("par_good_data", 32'(out_data), 32'hB);
    send_frame({1'b0, 4'b1011}, 1'b0, 1'b0);
    check("par_bad", 32'(parity_err), 32'd1);
    check("par_bad_data", 32'(out_data), 32'hB);
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      Clear     = ($urandom_range(0, 99) == 0);
      ser_valid = ($urandom_range(0, 9) < 7);
      ser_in    = 1'($urandom);
      sel_dir   = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    // Drain and confirm every expected word was delivered
    Clear = 1'b0;
    ser_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_receiver.md
# universal_shift_receiver

Serial-to-parallel receiver that reassembles words shifted out one bit per cycle by the universal shift register, in either shift direction. Sits at the far end of the serial link. Collects WIDTH bits, or WIDTH plus one parity bit when parity is enabled, into a one-entry output buffer. The buffer drains through a valid/ready handshake, and the block flags dropped words.

## Interface
- WIDTH, 4: data word width in bits; must be ≥ 2.
- CLK  input  1  clock; all state updates on the rising edge.
- Clear  input  1  synchronous, active-high reset.
- sel_dir  input  1  0 = LSB-first stream (transmitter shifting right); 1 = MSB-first stream (transmitter shifting left).
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in carries a bit this cycle.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity mismatch on the word in out_data.
- bit_count  output  $clog2(WIDTH+2)  bits collected in the current frame.

## Operation
- Two states:
  - COLLECT: accumulating bits.
  - Frame-complete: the cycle the last bit is accepted.
- A bit is accepted when ser_valid=1; otherwise the assembly register and bit_count hold.
- sel_dir is latched when the first bit of a frame is accepted (bit_count=0). Changes mid-frame are ignored until the next frame.
- sel_dir=0: the register shifts right and the new bit enters at bit WIDTH-1. After WIDTH bits, the first received bit sits at bit 0.
- sel_dir=1: the register shifts left and the new bit enters at bit 0. After WIDTH bits, the first received bit sits at bit WIDTH-1.
- Frame length FL = WIDTH, or WIDTH+1 with parity enabled. The parity bit is the last bit and never enters the data register.
- When the FL-th bit is accepted, the frame is complete:
  - bit_count returns to 0.
  - The word is offered to the output buffer.
- Buffer load: occurs if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle. out_valid is 1 next cycle and out_data holds the new word.
- Buffer full (out_valid=1, out_ready=0) at completion:
  - The new word is discarded.
  - overrun is set.
  - out_data is unchanged.
- overrun stays set until Clear.
- Handshake: the word transfers on a cycle where out_valid=1 and out_ready=1. out_valid falls next cycle unless a new word loads in that same cycle.
- out_data is stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_data=0, out_valid=0, overrun=0, parity_err=0, bit_count=0. The assembly register and latched direction are also 0.
- Clear=1 mid-frame discards the partial frame and any buffered word. Clear has priority over every other input.
- Latency: out_valid rises on the first edge after the edge that accepts the final bit, i.e. 1 cycle.
- Throughput: one word every FL valid cycles with out_ready held 1. No bubbles are inserted between back-to-back frames.
- Simultaneous final bit and drain: the new word replaces the old one and out_valid stays 1 continuously.
- bit_count counts 0..FL-1 and wraps to 0 on completion.

## Configuration
- SHIFT_RX_PARITY_EN defined:
  - FL=WIDTH+1, with even parity over data plus parity bit.
  - parity_err is registered alongside out_data: it is 1 if the XOR of all FL bits is 1.
  - It updates only when a word loads and clears when the buffer empties.
  - The word is delivered regardless of parity_err.
  - parity_err is subject to the same overrun rule as out_data.
- Not defined:
  - FL=WIDTH.
  - parity_err is tied to 0.
  - bit_count never exceeds WIDTH-1.

## Test plan
- Reset then LSB-first: Clear=1 for 2 cycles, then sel_dir=0, out_ready=1, ser_in = 1,1,0,1 on 4 valid cycles. Expect out_data=4'b1011 and out_valid=1 one cycle after the 4th bit, with all outputs 0 during reset.
- MSB-first: sel_dir=1, ser_in = 1,0,1,1. Expect out_data=4'b1011. Toggling sel_dir to 0 after the first bit leaves the result unchanged.
- Gaps and back-pressure: ser_valid deasserted for 3 cycles mid-frame, so bit_count holds at 2. Then with out_ready=0, a second full frame sets overrun=1, and out_data keeps its first word until out_ready=1.
- Back-to-back: 3 frames with ser_valid=1 continuously and out_ready=1. Expect out_valid high for one cycle every 4 cycles with correct words and overrun=0. Also check that a final bit coinciding with a drain keeps out_valid=1.
- Reset mid-frame: Clear=1 after 2 bits of frame 0101, then a fresh frame 0011 (sel_dir=0). Expect out_data=4'b1100 and no stale bits.
- SHIFT_RX_PARITY_EN: bits 1,1,0,1 with parity 1 give parity_err=0; with parity 0 they give parity_err=1. Both deliver out_data=4'b1011.
